// File: rtl/frame_accumulator_pkg.sv
// Shared definitions for the frame accumulator and the downstream rounder:
// default operand width and the two-state FSM encoding.
package frame_accumulator_pkg;

    localparam int DEFAULT_WIDTH = 16;

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_EMIT  = 1'b1;

endpackage

// File: rtl/sat_clip.sv
// Unsigned clamp from IN_W to OUT_W bits; flags when the input did not fit.
// Reused later at the rounder output.
module sat_clip #(
    parameter int IN_W  = 18,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  val_i,
    output logic [OUT_W-1:0] data_o,
    output logic             sat_o
);

    generate
        if (IN_W > OUT_W) begin : g_clip
            assign sat_o  = |val_i[IN_W-1:OUT_W];
            assign data_o = sat_o ? '1 : val_i[OUT_W-1:0];
        end else begin : g_pass
            // Input already fits: no saturation is ever possible.
            assign sat_o  = 1'b0;
            assign data_o = OUT_W'(val_i);
        end
    endgenerate

endmodule

// File: rtl/frame_accumulator.sv
// Sums frames of COUNT unsigned samples and emits one saturated WIDTH-bit sum
// per frame over a valid/ready handshake; feeds the rounder's operand A.
module frame_accumulator
    import frame_accumulator_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int COUNT = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [WIDTH-1:0] In_data,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [WIDTH-1:0] Out_data,
    output logic             Out_sat
);

    localparam int CNTW = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam int ACCW = WIDTH + $clog2(COUNT);

    logic [0:0]       state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [ACCW-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             sat_q, sat_d;

    logic [ACCW-1:0]  acc_next;
    logic [WIDTH-1:0] clip_data;
    logic             clip_sat;
    logic             last;

    assign In_ready  = (state_q == ST_ACCUM);
    assign Out_valid = (state_q == ST_EMIT);
    assign Out_data  = data_q;
    assign Out_sat   = sat_q;

    // First sample of a frame overwrites the accumulator instead of adding.
    assign acc_next = (cnt_q == '0) ? ACCW'(In_data) : acc_q + ACCW'(In_data);
    assign last     = (cnt_q == CNTW'(COUNT - 1));

    sat_clip #(
        .IN_W  (ACCW),
        .OUT_W (WIDTH)
    ) u_sat_clip (
        .val_i  (acc_next),
        .data_o (clip_data),
        .sat_o  (clip_sat)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        data_d  = data_q;
        sat_d   = sat_q;
        if (state_q == ST_ACCUM) begin
            if (In_valid) begin
                acc_d = acc_next;
                if (last) begin
                    state_d = ST_EMIT;
                    cnt_d   = '0;
                    data_d  = clip_data;
                    sat_d   = clip_sat;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
        end else begin
            // Output registers hold their value across the handshake.
            if (Out_ready) begin
                state_d = ST_ACCUM;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_ACCUM;
            cnt_q   <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            sat_q   <= sat_d;
        end
    end

endmodule

// File: tb/tb_frame_accumulator.sv
// Bench for frame_accumulator: vector table, directed corner cases and a
// randomized run against a queue-based frame-sum model (COUNT=4 and COUNT=1).
module tb_frame_accumulator;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid4, in_ready4, out_valid4, out_ready4, out_sat4;
    logic [W-1:0]  in_data4, out_data4;
    logic          in_valid1, in_ready1, out_valid1, out_ready1, out_sat1;
    logic [W-1:0]  in_data1, out_data1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    frame_accumulator #(.WIDTH(W), .COUNT(4)) u4 (
        .Clk(clk), .Rst(rst),
        .In_valid(in_valid4), .In_ready(in_ready4), .In_data(in_data4),
        .Out_valid(out_valid4), .Out_ready(out_ready4),
        .Out_data(out_data4), .Out_sat(out_sat4)
    );

    frame_accumulator #(.WIDTH(W), .COUNT(1)) u1 (
        .Clk(clk), .Rst(rst),
        .In_valid(in_valid1), .In_ready(in_ready1), .In_data(in_data1),
        .Out_valid(out_valid1), .Out_ready(out_ready1),
        .Out_data(out_data1), .Out_sat(out_sat1)
    );

    typedef struct {
        logic [3:0][W-1:0] d;
        logic [W-1:0]      exp_data;
        logic              exp_sat;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    // Apply inputs, let one active edge pass, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        in_valid4 = 1'b0; in_valid1 = 1'b0;
        for (int i = 0; i < n; i++) tick();
        rst = 1'b0;
    endtask

    // Send four back-to-back samples to u4 and check the emit cycle.
    task automatic send_frame4(input string nm, input logic [3:0][W-1:0] d,
                               input logic [W-1:0] ed, input logic es);
        out_ready4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid4 = 1'b1;
            in_data4  = d[i];
            chk({nm, "_inrdy"}, 32'(in_ready4), 32'd1);
            tick();
            if (i < 3) chk({nm, "_early_vld"}, 32'(out_valid4), 32'd0);
        end
        in_valid4 = 1'b0;
        in_data4  = W'($urandom);
        chk({nm, "_vld"}, 32'(out_valid4), 32'd1);
        chk({nm, "_data"}, 32'(out_data4), 32'(ed));
        chk({nm, "_sat"}, 32'(out_sat4), 32'(es));
        chk({nm, "_inrdy_emit"}, 32'(in_ready4), 32'd0);
        tick();
        chk({nm, "_vld_drop"}, 32'(out_valid4), 32'd0);
        chk({nm, "_inrdy_back"}, 32'(in_ready4), 32'd1);
        chk({nm, "_data_hold"}, 32'(out_data4), 32'(ed));
    endtask

    // Behavioural reference for the randomized run
    int unsigned frame_q[$];
    bit          m_pending;
    logic [W-1:0] m_data;
    bit          m_sat;

    task automatic model_step(input int count, input bit iv, input logic [W-1:0] id,
                              input bit ordy);
        longint unsigned sum;
        if (m_pending) begin
            if (ordy) m_pending = 0;
        end else if (iv) begin
            frame_q.push_back(int'(id));
            if (frame_q.size() == count) begin
                sum = 0;
                foreach (frame_q[k]) sum += longint'(frame_q[k]);
                m_sat  = (sum > 64'hFFFF);
                m_data = m_sat ? 16'hFFFF : sum[15:0];
                m_pending = 1;
                frame_q.delete();
            end
        end
    endtask

    function automatic logic [W-1:0] rand_sample();
        if ($urandom_range(0, 3) == 0) return 16'hFFFF - W'($urandom_range(0, 3));
        return W'($urandom);
    endfunction

    initial begin
        vecs[0] = '{d: {16'd4, 16'd3, 16'd2, 16'd1},               exp_data: 16'h000A, exp_sat: 1'b0};
        vecs[1] = '{d: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},   exp_data: 16'hFFFF, exp_sat: 1'b1};
        vecs[2] = '{d: {16'd0, 16'd0, 16'd1, 16'hFFFF},            exp_data: 16'hFFFF, exp_sat: 1'b1};
        vecs[3] = '{d: {16'd0, 16'd0, 16'd1, 16'hFFFE},            exp_data: 16'hFFFF, exp_sat: 1'b0};
        vecs[4] = '{d: {16'd5, 16'd5, 16'd5, 16'd5},               exp_data: 16'h0014, exp_sat: 1'b0};

        rst = 1'b1;
        in_valid4 = 1'b0; in_data4 = '0; out_ready4 = 1'b1;
        in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b1;
        #2;
        do_reset(2);

        chk("rst_vld", 32'(out_valid4), 32'd0);
        chk("rst_data", 32'(out_data4), 32'd0);
        chk("rst_sat", 32'(out_sat4), 32'd0);
        chk("rst_inrdy", 32'(in_ready4), 32'd1);

        for (int v = 0; v < 5; v++)
            send_frame4($sformatf("vec%0d", v), vecs[v].d, vecs[v].exp_data, vecs[v].exp_sat);

        // Backpressure: hold 6 cycles while garbage is offered on the input
        out_ready4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid4 = 1'b1; in_data4 = 16'd5; tick();
        end
        for (int c = 0; c < 6; c++) begin
            in_valid4 = 1'b1; in_data4 = W'($urandom);
            chk("bp_vld", 32'(out_valid4), 32'd1);
            chk("bp_data", 32'(out_data4), 32'h14);
            chk("bp_inrdy", 32'(in_ready4), 32'd0);
            if (c < 5) tick();
        end
        in_valid4 = 1'b0; out_ready4 = 1'b1;
        tick();
        chk("bp_release_vld", 32'(out_valid4), 32'd0);
        chk("bp_release_inrdy", 32'(in_ready4), 32'd1);
        send_frame4("bp_after", {16'd1, 16'd1, 16'd1, 16'd1}, 16'h0004, 1'b0);

        // Input gaps with garbage on invalid cycles
        begin
            bit            gv[7] = '{1, 0, 0, 1, 0, 1, 1};
            logic [W-1:0]  gd[7] = '{16'd7, 16'd0, 16'd0, 16'd8, 16'd0, 16'd9, 16'd10};
            for (int i = 0; i < 7; i++) begin
                in_valid4 = gv[i];
                in_data4  = gv[i] ? gd[i] : W'($urandom);
                tick();
                if (i < 6) chk("gap_early_vld", 32'(out_valid4), 32'd0);
            end
            in_valid4 = 1'b0;
            chk("gap_vld", 32'(out_valid4), 32'd1);
            chk("gap_data", 32'(out_data4), 32'h22);
            tick();
        end

        // Reset mid-frame discards the partial sum
        in_valid4 = 1'b1; in_data4 = 16'd100; tick();
        in_data4 = 16'd200; tick();
        do_reset(1);
        send_frame4("rst_mid", {16'd1, 16'd1, 16'd1, 16'd1}, 16'h0004, 1'b0);

        // Reset while a sum is pending
        out_ready4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid4 = 1'b1; in_data4 = W'(i + 1); tick();
        end
        in_valid4 = 1'b0;
        chk("rst_emit_pre_vld", 32'(out_valid4), 32'd1);
        do_reset(1);
        chk("rst_emit_vld", 32'(out_valid4), 32'd0);
        chk("rst_emit_data", 32'(out_data4), 32'd0);
        out_ready4 = 1'b1;

        // COUNT=1 pass-through
        in_valid1 = 1'b1; in_data1 = 16'h1234; out_ready1 = 1'b1;
        chk("c1_inrdy0", 32'(in_ready1), 32'd1);
        tick();
        chk("c1_vld0", 32'(out_valid1), 32'd1);
        chk("c1_data0", 32'(out_data1), 32'h1234);
        chk("c1_sat0", 32'(out_sat1), 32'd0);
        chk("c1_inrdy1", 32'(in_ready1), 32'd0);
        in_data1 = 16'hFFFF;
        tick();
        chk("c1_gap_vld", 32'(out_valid1), 32'd0);
        chk("c1_inrdy2", 32'(in_ready1), 32'd1);
        tick();
        chk("c1_vld1", 32'(out_valid1), 32'd1);
        chk("c1_data1", 32'(out_data1), 32'hFFFF);
        chk("c1_sat1", 32'(out_sat1), 32'd0);
        in_valid1 = 1'b0;
        tick();

        // Randomized run for COUNT=4 against the frame-sum model
        do_reset(1);
        frame_q.delete(); m_pending = 0; m_data = '0; m_sat = 0;
        for (int c = 0; c < 400; c++) begin
            bit iv, ordy;
            logic [W-1:0] id;
            iv   = ($urandom_range(0, 9) < 6);
            ordy = ($urandom_range(0, 1) == 1);
            id   = rand_sample();
            in_valid4 = iv; in_data4 = id; out_ready4 = ordy;
            chk("rnd_inrdy", 32'(in_ready4), 32'(!m_pending));
            model_step(4, iv, id, ordy);
            tick();
            chk("rnd_vld", 32'(out_valid4), 32'(m_pending));
            chk("rnd_data", 32'(out_data4), 32'(m_data));
            chk("rnd_sat", 32'(out_sat4), 32'(m_sat));
        end
        in_valid4 = 1'b0; out_ready4 = 1'b1;

        // Randomized run for COUNT=1
        do_reset(1);
        frame_q.delete(); m_pending = 0; m_data = '0; m_sat = 0;
        for (int c = 0; c < 200; c++) begin
            bit iv, ordy;
            logic [W-1:0] id;
            iv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 2) != 0);
            id   = rand_sample();
            in_valid1 = iv; in_data1 = id; out_ready1 = ordy;
            model_step(1, iv, id, ordy);
            tick();
            chk("rnd1_vld", 32'(out_valid1), 32'(m_pending));
            chk("rnd1_data", 32'(out_data1), 32'(m_data));
            chk("rnd1_sat", 32'(out_sat1), 32'(m_sat));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
